// File: rtl/bdl_pkg.sv
// Shared constants and types for the DELQA buffer-descriptor ring.
// Word indices name the fixed layout of one descriptor.
package bdl_pkg;

  localparam int BDL_WPD    = 6;
  localparam int BDL_W_FLAG = 0;
  localparam int BDL_W_ADRH = 1;
  localparam int BDL_W_ADRL = 2;
  localparam int BDL_W_LEN  = 3;
  localparam int BDL_W_ST1  = 4;
  localparam int BDL_W_ST2  = 5;

  typedef logic [15:0] bdl_word_t;

endpackage : bdl_pkg

// File: rtl/bdl_slot.sv
// One descriptor slot: WPD words of DW flops, one indexed write port,
// a synchronous clear and a combinational indexed read.
module bdl_slot #(
  parameter int DW  = 16,
  parameter int WPD = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   we,
  input  logic [$clog2(WPD)-1:0] widx,
  input  logic [DW-1:0]          wdata,
  input  logic [$clog2(WPD)-1:0] ridx,
  output logic [DW-1:0]          rdata
);

  localparam int IW = $clog2(WPD);

  logic [DW-1:0] mem [WPD];
  logic          widx_ok;
  logic          ridx_ok;

  // The extra bit keeps the range check correct when WPD is a power of two.
  assign widx_ok = ({1'b0, widx} < (IW+1)'(WPD));
  assign ridx_ok = ({1'b0, ridx} < (IW+1)'(WPD));

  // Clear wins over a coincident write so a released slot never keeps a late write.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < WPD; i++) begin
        mem[i] <= '0;
      end
    end else if (we && widx_ok) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = ridx_ok ? mem[ridx] : '0;

endmodule : bdl_slot

// File: rtl/bdl_desc_ring.sv
// Ring of NDESC buffer descriptors filled word by word, read/written back at the head.
// Optional BDL_CLR_ON_POP_EN: zero a slot when it is popped and zero all slots on flush.
module bdl_desc_ring
  import bdl_pkg::*;
#(
  parameter int DW    = 16,
  parameter int WPD   = BDL_WPD,
  parameter int NDESC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  output logic                       wr_ready,
  output logic                       wr_ovf,
  output logic                       desc_done,
  output logic                       rd_valid,
  input  logic [$clog2(WPD)-1:0]     rd_idx,
  output logic [DW-1:0]              rd_data,
  input  logic                       st_we,
  input  logic [$clog2(WPD)-1:0]     st_idx,
  input  logic [DW-1:0]              st_data,
  input  logic                       pop,
  output logic [$clog2(NDESC+1)-1:0] count
);

  localparam int IW = $clog2(WPD);
  localparam int PW = $clog2(NDESC);
  localparam int CW = $clog2(NDESC+1);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [IW-1:0] wc;

  logic          fill_acc;
  logic          fill_last;
  logic          do_pop;
  logic          st_ok;

  logic [NDESC-1:0] slot_we;
  logic [NDESC-1:0] slot_clr;
  logic [IW-1:0]    slot_widx  [NDESC];
  logic [DW-1:0]    slot_wdata [NDESC];
  logic [DW-1:0]    slot_rdata [NDESC];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(NDESC-1)) ? '0 : p + 1'b1;
  endfunction

  // Handshakes: a fill word transfers only in a cycle with wr_en && wr_ready
  // (wr_en without wr_ready is dropped and flagged one cycle later on wr_ovf);
  // the head descriptor is consumable while rd_valid is high, and pop/st_we
  // act on it only then.
  assign wr_ready  = (count < CW'(NDESC));
  assign rd_valid  = (count != '0);
  assign fill_acc  = wr_en && wr_ready && !flush;
  assign fill_last = fill_acc && (wc == IW'(WPD-1));
  assign do_pop    = pop && rd_valid && !flush;
  assign st_ok     = st_we && rd_valid && !flush && ({1'b0, st_idx} < (IW+1)'(WPD));

  // Fill and write-back cannot collide: tail==head with a partial fill means empty.
  always_comb begin
    slot_we  = '0;
    slot_clr = '0;
    for (int i = 0; i < NDESC; i++) begin
      slot_widx[i]  = '0;
      slot_wdata[i] = '0;
      if (fill_acc && (tail == PW'(i))) begin
        slot_we[i]    = 1'b1;
        slot_widx[i]  = wc;
        slot_wdata[i] = wr_data;
      end else if (st_ok && (head == PW'(i))) begin
        slot_we[i]    = 1'b1;
        slot_widx[i]  = st_idx;
        slot_wdata[i] = st_data;
      end
`ifdef BDL_CLR_ON_POP_EN
      slot_clr[i] = flush || (do_pop && (head == PW'(i)));
`endif
    end
  end

  for (genvar g = 0; g < NDESC; g++) begin : g_slot
    bdl_slot #(
      .DW  (DW),
      .WPD (WPD)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .clr   (slot_clr[g]),
      .we    (slot_we[g]),
      .widx  (slot_widx[g]),
      .wdata (slot_wdata[g]),
      .ridx  (rd_idx),
      .rdata (slot_rdata[g])
    );
  end

  assign rd_data = rd_valid ? slot_rdata[head] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head      <= '0;
      tail      <= '0;
      wc        <= '0;
      count     <= '0;
      wr_ovf    <= 1'b0;
      desc_done <= 1'b0;
    end else begin
      wr_ovf    <= wr_en && !wr_ready;
      desc_done <= fill_last;
      if (fill_last) begin
        wc   <= '0;
        tail <= ptr_next(tail);
      end else if (fill_acc) begin
        wc <= wc + 1'b1;
      end
      if (do_pop) begin
        head <= ptr_next(head);
      end
      // Commit and pop together leave the occupancy unchanged.
      case ({fill_last, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : bdl_desc_ring

// File: tb/tb_bdl_desc_ring.sv
// Bench for bdl_desc_ring: an NDESC=4 and an NDESC=3 instance share one stimulus
// stream and are checked against a queue-based descriptor model.
module tb_bdl_desc_ring;
  import bdl_pkg::*;

  localparam int DW  = 16;
  localparam int WPD = BDL_WPD;
  localparam int IW  = $clog2(WPD);

  typedef logic [WPD*DW-1:0] desc_t;

  logic          clk = 1'b0;
  logic          rst, flush, wr_en, st_we, pop;
  logic [DW-1:0] wr_data, st_data;
  logic [IW-1:0] rd_idx, st_idx;

  logic          wr_ready4, wr_ovf4, desc_done4, rd_valid4;
  logic [DW-1:0] rd_data4;
  logic [2:0]    count4;
  logic          wr_ready3, wr_ovf3, desc_done3, rd_valid3;
  logic [DW-1:0] rd_data3;
  logic [1:0]    count3;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  bdl_desc_ring #(.DW(DW), .WPD(WPD), .NDESC(4)) u4 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ready(wr_ready4), .wr_ovf(wr_ovf4), .desc_done(desc_done4),
    .rd_valid(rd_valid4), .rd_idx(rd_idx), .rd_data(rd_data4),
    .st_we(st_we), .st_idx(st_idx), .st_data(st_data), .pop(pop), .count(count4)
  );

  bdl_desc_ring #(.DW(DW), .WPD(WPD), .NDESC(3)) u3 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ready(wr_ready3), .wr_ovf(wr_ovf3), .desc_done(desc_done3),
    .rd_valid(rd_valid3), .rd_idx(rd_idx), .rd_data(rd_data3),
    .st_we(st_we), .st_idx(st_idx), .st_data(st_data), .pop(pop), .count(count3)
  );

  // ---------------- reference model ----------------
  desc_t mq0[$];
  desc_t mq1[$];
  desc_t part0, part1;
  int    pwc0, pwc1;
  logic  exp_ovf  [2];
  logic  exp_done [2];

  task automatic model_clk();
    desc_t tq[$];
    desc_t tp, h;
    int    tw, nd;
    logic  full, commit;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin tq = mq0; tp = part0; tw = pwc0; nd = 4; end
      else        begin tq = mq1; tp = part1; tw = pwc1; nd = 3; end
      exp_ovf[k]  = 1'b0;
      exp_done[k] = 1'b0;
      if (rst || flush) begin
        tq.delete();
        tp = '0;
        tw = 0;
      end else begin
        full       = (tq.size() >= nd);
        exp_ovf[k] = wr_en && full;
        commit     = 1'b0;
        if (wr_en && !full) begin
          tp[tw*DW +: DW] = wr_data;
          tw++;
          if (tw == WPD) begin commit = 1'b1; tw = 0; end
        end
        if (st_we && tq.size() > 0 && int'(st_idx) < WPD) begin
          h = tq[0];
          h[int'(st_idx)*DW +: DW] = st_data;
          tq[0] = h;
        end
        if (pop && tq.size() > 0) void'(tq.pop_front());
        if (commit) begin
          tq.push_back(tp);
          tp = '0;
          exp_done[k] = 1'b1;
        end
      end
      if (k == 0) begin mq0 = tq; part0 = tp; pwc0 = tw; end
      else        begin mq1 = tq; part1 = tp; pwc1 = tw; end
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input int k, input int idx);
    desc_t h;
    if (idx >= WPD) return '0;
    if (k == 0) begin
      if (mq0.size() == 0) return '0;
      h = mq0[0];
    end else begin
      if (mq1.size() == 0) return '0;
      h = mq1[0];
    end
    return h[idx*DW +: DW];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " count4"},    32'(count4),     32'(mq0.size()));
    check({tag, " rd_valid4"}, 32'(rd_valid4),  32'(mq0.size() != 0));
    check({tag, " wr_ready4"}, 32'(wr_ready4),  32'(mq0.size() < 4));
    check({tag, " wr_ovf4"},   32'(wr_ovf4),    32'(exp_ovf[0]));
    check({tag, " done4"},     32'(desc_done4), 32'(exp_done[0]));
    check({tag, " rd_data4"},  32'(rd_data4),   32'(exp_word(0, int'(rd_idx))));
    check({tag, " count3"},    32'(count3),     32'(mq1.size()));
    check({tag, " rd_valid3"}, 32'(rd_valid3),  32'(mq1.size() != 0));
    check({tag, " wr_ready3"}, 32'(wr_ready3),  32'(mq1.size() < 3));
    check({tag, " wr_ovf3"},   32'(wr_ovf3),    32'(exp_ovf[1]));
    check({tag, " done3"},     32'(desc_done3), 32'(exp_done[1]));
    check({tag, " rd_data3"},  32'(rd_data3),   32'(exp_word(1, int'(rd_idx))));
  endtask

  // Walk every rd_idx (including out-of-range ones) between clock edges.
  task automatic sweep(input string tag);
    logic [IW-1:0] keep;
    keep = rd_idx;
    for (int i = 0; i < (1 << IW); i++) begin
      rd_idx = IW'(i);
      #1;
      check({tag, " sweep4"}, 32'(rd_data4), 32'(exp_word(0, i)));
      check({tag, " sweep3"}, 32'(rd_data3), 32'(exp_word(1, i)));
    end
    rd_idx = keep;
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic f_rst, input logic f_flush,
                      input logic f_wr, input logic [DW-1:0] wd,
                      input logic f_st, input logic [IW-1:0] si, input logic [DW-1:0] sd,
                      input logic f_pop, input logic [IW-1:0] ri);
    @(negedge clk);
    rst = f_rst; flush = f_flush; wr_en = f_wr; wr_data = wd;
    st_we = f_st; st_idx = si; st_data = sd; pop = f_pop; rd_idx = ri;
    model_clk();
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; st_we = 1'b0; pop = 1'b0;
    check_all(tag);
  endtask

  task automatic fill_desc(input string tag, input logic [DW-1:0] base, input logic [IW-1:0] ri);
    for (int i = 0; i < WPD; i++) begin
      step(tag, 1'b0, 1'b0, 1'b1, base + DW'(i), 1'b0, '0, '0, 1'b0, ri);
    end
  endtask

  task automatic do_pop(input string tag, input logic [IW-1:0] ri);
    step(tag, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, ri);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; st_we = 1'b0; pop = 1'b0;
    wr_data = '0; st_data = '0; rd_idx = '0; st_idx = '0;
    exp_ovf[0] = 1'b0; exp_ovf[1] = 1'b0; exp_done[0] = 1'b0; exp_done[1] = 1'b0;
    part0 = '0; part1 = '0; pwc0 = 0; pwc1 = 0;

    step("reset", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    step("reset2", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    sweep("reset");

    // First descriptor 0x1111..0x6666, observed at word 3.
    for (int i = 0; i < WPD; i++) begin
      step("t1", 1'b0, 1'b0, 1'b1, DW'((i + 1) * 16'h1111), 1'b0, '0, '0, 1'b0, 3'd3);
    end
    check("t1 head word3", 32'(rd_data4), 32'h4444);

    // Fill to capacity, then one extra word overflows.
    fill_desc("t2", 16'h2000, 3'd0);
    fill_desc("t2", 16'h3000, 3'd0);
    fill_desc("t2", 16'h4000, 3'd0);
    step("t2 ovf", 1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0, '0, '0, 1'b0, 3'd0);
    sweep("t2");

    // Write-back into a present head.
    step("t4 st", 1'b0, 1'b0, 1'b0, '0, 1'b1, 3'd4, 16'hBEEF, 1'b0, 3'd4);
    check("t4 beef", 32'(rd_data4), 32'hBEEF);
    sweep("t4");
    for (int i = 0; i < 4; i++) begin
      do_pop("t4 drain", 3'(i % WPD));
      sweep("t4 drain");
    end
    step("t4 st empty", 1'b0, 1'b0, 1'b0, '0, 1'b1, 3'd4, 16'hBEEF, 1'b0, 3'd4);
    do_pop("t4 pop empty", 3'd0);

    // Seven commit/pop rounds wrap both rings.
    for (int n = 0; n < 7; n++) begin
      fill_desc("t3", DW'(16'h0A00 + n * 16'h0100), 3'd0);
      do_pop("t3 pop", 3'd0);
    end

    // Commit and pop in the same cycle at count==2.
    fill_desc("t5", 16'h5100, 3'd0);
    fill_desc("t5", 16'h5200, 3'd0);
    for (int i = 0; i < WPD - 1; i++) begin
      step("t5", 1'b0, 1'b0, 1'b1, DW'(16'h5300 + i), 1'b0, '0, '0, 1'b0, 3'd0);
    end
    step("t5 last+pop", 1'b0, 1'b0, 1'b1, 16'h5305, 1'b0, '0, '0, 1'b1, 3'd0);
    check("t5 count", 32'(count4), 32'd2);
    check("t5 head", 32'(rd_data4), 32'h5200);

    // Partial fill discarded by flush, then a fresh descriptor.
    for (int i = 0; i < 3; i++) begin
      step("t6 part", 1'b0, 1'b0, 1'b1, DW'(16'h6600 + i), 1'b0, '0, '0, 1'b0, 3'd0);
    end
    step("t6 flush", 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, '0, '0, 1'b1, 3'd0);
    fill_desc("t6 refill", 16'h7700, 3'd2);
    sweep("t6");
    do_pop("t6 pop", 3'd0);
    sweep("t6 popped");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step("rand",
           1'b0,
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 6),
           DW'($urandom),
           ($urandom_range(0, 4) == 0),
           IW'($urandom_range(0, 7)),
           DW'($urandom),
           ($urandom_range(0, 3) == 0),
           IW'($urandom_range(0, 7)));
      if (n % 16 == 15) sweep("rand");
    end

    step("final reset", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    sweep("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bdl_desc_ring
